// File: rtl/bus_protocol_monitor.sv
// Passive checker for the dValid/dAck/data bus: sticky flags, error pulse, saturating counters.
// Define BUS_MON_FIRST_ERR_EN to capture the flags and burst index of the first erroneous burst.
module bus_protocol_monitor #(
  parameter int DATA_W    = 8,
  parameter int MIN_VALID = 2,
  parameter int MAX_VALID = 4,
  parameter int ACK_MIN   = 2,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dValid,
  input  logic              dAck,
  input  logic [DATA_W-1:0] data,
  input  logic              clr_err,
  output logic [3:0]        err_flags,
  output logic              err_pulse,
  output logic              xfer_done,
  output logic [CNT_W-1:0]  xfer_count,
  output logic [CNT_W-1:0]  err_count,
  output logic [3:0]        first_err_code,
  output logic [CNT_W-1:0]  first_err_idx
);

  localparam int E_LEN  = 0;
  localparam int E_DATA = 1;
  localparam int E_ACK  = 2;
  localparam int E_DROP = 3;

  localparam logic [4:0] MIN_N  = 5'(MIN_VALID);
  localparam logic [4:0] MAX_N  = 5'(MAX_VALID);
  localparam logic [4:0] OVER_N = 5'(MAX_VALID + 1);
  localparam logic [4:0] ACK_N  = 5'(ACK_MIN);

  typedef enum logic [1:0] {IDLE, VALID, ACKED, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [4:0]        n, n_nxt, cur;
  logic [DATA_W-1:0] cap;
  logic [3:0]        burst_err, viol, new_err, all_err;
  logic              start, burst_end;
  logic [CNT_W-1:0]  xfer_base, err_base, xfer_inc, err_inc;

  // The first dValid cycle is judged in IDLE as burst cycle 1; later cycles in VALID as n+1.
  always_comb begin
    viol      = '0;
    state_nxt = state;
    n_nxt     = n;
    start     = 1'b0;
    burst_end = 1'b0;
    cur       = n + 5'd1;
    case (state)
      IDLE: begin
        if (dValid) begin
          start = 1'b1;
          n_nxt = 5'd1;
          if (dAck) begin
            if (ACK_N > 5'd1) begin
              viol[E_ACK] = 1'b1;
              state_nxt   = DRAIN;
              burst_end   = 1'b1;
            end else begin
              state_nxt = ACKED;
            end
          end else begin
            state_nxt = VALID;
          end
        end else if (dAck) begin
          viol[E_ACK] = 1'b1;
          burst_end   = 1'b1;
        end
      end
      VALID: begin
        if (dValid) begin
          n_nxt = cur;
          if (data != cap) viol[E_DATA] = 1'b1;
          if (cur == OVER_N) begin
            viol[E_LEN] = 1'b1;
            viol[E_ACK] = 1'b1;
            state_nxt   = DRAIN;
            burst_end   = 1'b1;
          end else if (dAck) begin
            if (cur < ACK_N) begin
              viol[E_ACK] = 1'b1;
              state_nxt   = DRAIN;
              burst_end   = 1'b1;
            end else begin
              state_nxt = ACKED;
            end
          end
        end else begin
          viol[E_ACK] = 1'b1;
          viol[E_LEN] = (n < MIN_N);
          state_nxt   = IDLE;
          burst_end   = 1'b1;
        end
      end
      ACKED: begin
        burst_end = 1'b1;
        if (dValid) begin
          viol[E_DROP] = 1'b1;
          state_nxt    = DRAIN;
        end else begin
          viol[E_LEN] = (n < MIN_N) || (n > MAX_N);
          state_nxt   = IDLE;
        end
      end
      default: begin
        if (!dValid) state_nxt = IDLE;
      end
    endcase

    // A flag already raised earlier in this burst does not pulse again.
    new_err   = viol & ~burst_err;
    all_err   = burst_err | viol;
    xfer_base = clr_err ? '0 : xfer_count;
    err_base  = clr_err ? '0 : err_count;
    xfer_inc  = (&xfer_base) ? xfer_base : xfer_base + CNT_W'(1);
    err_inc   = (&err_base) ? err_base : err_base + CNT_W'(1);
  end

  // Clear from clr_err is applied first so a violation on the same edge survives it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= DRAIN;
      n          <= '0;
      cap        <= '0;
      burst_err  <= '0;
      err_flags  <= '0;
      err_pulse  <= 1'b0;
      xfer_done  <= 1'b0;
      xfer_count <= '0;
      err_count  <= '0;
    end else begin
      state      <= state_nxt;
      n          <= n_nxt;
      if (start) cap <= data;
      burst_err  <= burst_end ? 4'b0 : all_err;
      err_pulse  <= |new_err;
      xfer_done  <= burst_end && (all_err == 4'b0);
      err_flags  <= (clr_err ? 4'b0 : err_flags) | new_err;
      xfer_count <= (burst_end && (all_err == 4'b0)) ? xfer_inc : xfer_base;
      err_count  <= (burst_end && (all_err != 4'b0)) ? err_inc : err_base;
    end
  end

`ifdef BUS_MON_FIRST_ERR_EN
  logic first_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      first_valid    <= 1'b0;
      first_err_code <= '0;
      first_err_idx  <= '0;
    end else if (burst_end && (all_err != 4'b0) && (clr_err || !first_valid)) begin
      first_valid    <= 1'b1;
      first_err_code <= all_err;
      first_err_idx  <= xfer_base + err_inc;
    end else if (clr_err) begin
      first_valid    <= 1'b0;
      first_err_code <= '0;
      first_err_idx  <= '0;
    end
  end
`else
  assign first_err_code = '0;
  assign first_err_idx  = '0;
`endif

endmodule

// File: tb/tb_bus_protocol_monitor.sv
// Self-checking bench for bus_protocol_monitor: directed scenarios plus randomized bursts
// judged by a transaction-level model on a default instance and a reconfigured instance.
module tb_bus_protocol_monitor;

`ifdef BUS_MON_FIRST_ERR_EN
  localparam bit FIRST_EN = 1'b1;
`else
  localparam bit FIRST_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        dValid1 = 1'b0, dAck1 = 1'b0, clr1 = 1'b0;
  logic [7:0]  data1 = '0;
  logic        dValid2 = 1'b0, dAck2 = 1'b0, clr2 = 1'b0;
  logic [15:0] data2 = '0;
  logic [3:0]  flags1, flags2, code1, code2;
  logic        errPulse1, errPulse2, done1, done2;
  logic [15:0] xfer1, err1, idx1;
  logic [1:0]  xfer2, err2, idx2;

  int n_checks = 0;
  int n_fail = 0;

  int min_v[2]   = '{2, 3};
  int max_v[2]   = '{4, 6};
  int ack_min[2] = '{2, 3};
  int cnt_max[2] = '{65535, 3};

  logic [3:0] exp_flags[2];
  logic [3:0] exp_code[2];
  int         exp_idx[2];
  bit         first_seen[2];
  int         exp_xfer[2], exp_err[2], exp_done[2], exp_errp[2];
  int         obs_done[2] = '{0, 0};
  int         obs_errp[2] = '{0, 0};

  always #5 clk = ~clk;

  bus_protocol_monitor u_dut (
    .clk(clk), .reset(reset), .dValid(dValid1), .dAck(dAck1), .data(data1), .clr_err(clr1),
    .err_flags(flags1), .err_pulse(errPulse1), .xfer_done(done1), .xfer_count(xfer1),
    .err_count(err1), .first_err_code(code1), .first_err_idx(idx1)
  );

  bus_protocol_monitor #(
    .DATA_W(16), .MIN_VALID(3), .MAX_VALID(6), .ACK_MIN(3), .CNT_W(2)
  ) u_dut2 (
    .clk(clk), .reset(reset), .dValid(dValid2), .dAck(dAck2), .data(data2), .clr_err(clr2),
    .err_flags(flags2), .err_pulse(errPulse2), .xfer_done(done2), .xfer_count(xfer2),
    .err_count(err2), .first_err_code(code2), .first_err_idx(idx2)
  );

  // Pulse outputs are tallied every cycle so scenarios can compare totals against the model.
  always @(negedge clk) begin
    if (reset) begin
      if (done1)     obs_done[0] <= obs_done[0] + 1;
      if (errPulse1) obs_errp[0] <= obs_errp[0] + 1;
      if (done2)     obs_done[1] <= obs_done[1] + 1;
      if (errPulse2) obs_errp[1] <= obs_errp[1] + 1;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [3:0] obs_flags(input int sel);
    return (sel == 0) ? flags1 : flags2;
  endfunction
  function automatic int obs_xfer(input int sel);
    return (sel == 0) ? int'(xfer1) : int'(xfer2);
  endfunction
  function automatic int obs_err(input int sel);
    return (sel == 0) ? int'(err1) : int'(err2);
  endfunction
  function automatic logic [3:0] obs_code(input int sel);
    return (sel == 0) ? code1 : code2;
  endfunction
  function automatic int obs_idx(input int sel);
    return (sel == 0) ? int'(idx1) : int'(idx2);
  endfunction

  task automatic set_in(input int sel, input logic v, input logic k, input logic [15:0] d,
                        input logic c);
    if (sel == 0) begin
      dValid1 = v; dAck1 = k; data1 = d[7:0]; clr1 = c;
    end else begin
      dValid2 = v; dAck2 = k; data2 = d; clr2 = c;
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      exp_flags[s] = '0; exp_code[s] = '0; exp_idx[s] = 0; first_seen[s] = 1'b0;
      exp_xfer[s] = 0; exp_err[s] = 0;
    end
  endtask

  task automatic model_clear(input int sel);
    exp_flags[sel] = '0; exp_code[sel] = '0; exp_idx[sel] = 0; first_seen[sel] = 1'b0;
    exp_xfer[sel] = 0; exp_err[sel] = 0;
  endtask

  // Whole-burst verdict from the burst's length L, ack cycle a (0 = none), data-change cycle c.
  function automatic void model_burst(input int sel, input int L, input int a, input int c,
                                      output logic [3:0] e, output int pulses);
    int ov, t_end, win_end;
    bit data_err;
    ov = max_v[sel] + 1;
    if (a != 0 && a < ov) begin
      win_end = a;
      if (a < ack_min[sel]) begin
        e = 4'b0100; t_end = a;
      end else if (L > a) begin
        e = 4'b1000; t_end = a + 1;
      end else begin
        e = (a < min_v[sel]) ? 4'b0001 : 4'b0000; t_end = a + 1;
      end
    end else if (L >= ov) begin
      e = 4'b0101; t_end = ov; win_end = ov;
    end else begin
      e = (L < min_v[sel]) ? 4'b0101 : 4'b0100; t_end = L + 1; win_end = L;
    end
    data_err = (c >= 2) && (c <= win_end);
    pulses = (data_err ? 1 : 0) + ((e != 0) ? 1 : 0) - ((data_err && e != 0 && c == t_end) ? 1 : 0);
    if (data_err) e = e | 4'b0010;
  endfunction

  task automatic model_end(input int sel, input logic [3:0] e);
    if (e == 4'b0) begin
      if (exp_xfer[sel] < cnt_max[sel]) exp_xfer[sel]++;
      exp_done[sel]++;
    end else begin
      if (exp_err[sel] < cnt_max[sel]) exp_err[sel]++;
      exp_flags[sel] = exp_flags[sel] | e;
      if (!first_seen[sel]) begin
        first_seen[sel] = 1'b1;
        exp_code[sel] = e;
        exp_idx[sel] = (exp_xfer[sel] + exp_err[sel]) & cnt_max[sel];
      end
    end
  endtask

  task automatic do_clear(input int sel);
    @(negedge clk); set_in(sel, 1'b0, 1'b0, 16'h0, 1'b1);
    @(negedge clk); set_in(sel, 1'b0, 1'b0, 16'h0, 1'b0);
    model_clear(sel);
  endtask

  // One burst of L cycles, G idle cycles (spurious acks from bit g of spur for g >= 2).
  task automatic applyStimulus(input int sel, input int L, input int a, input int c, input int G,
                               input logic [15:0] d, input int spur);
    logic [3:0] e;
    int p;
    for (int i = 1; i <= L; i++) begin
      @(negedge clk);
      set_in(sel, 1'b1, (i == a), (c != 0 && i >= c) ? (d ^ 16'h0001) : d, 1'b0);
    end
    for (int g = 1; g <= G; g++) begin
      @(negedge clk);
      set_in(sel, 1'b0, (g >= 2) && (((spur >> g) & 1) != 0), 16'($urandom), 1'b0);
    end
    @(negedge clk); set_in(sel, 1'b0, 1'b0, d, 1'b0);
    model_burst(sel, L, a, c, e, p);
    model_end(sel, e);
    exp_errp[sel] += p;
    for (int g = 2; g <= G; g++) begin
      if (((spur >> g) & 1) != 0) begin
        model_end(sel, 4'b0100);
        exp_errp[sel]++;
      end
    end
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (flags1 !== 4'b0) begin n_fail++; $display("[TB] FAIL reset_flags: got %b expected 0000", flags1); end
    n_checks++; if (xfer1 !== 16'd0 || err1 !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_counts: got %0d/%0d expected 0/0", xfer1, err1); end
    n_checks++; if (errPulse1 !== 1'b0 || done1 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pulses: got %b/%b expected 0/0", errPulse1, done1); end
    n_checks++; if (flags2 !== 4'b0 || xfer2 !== 2'd0 || err2 !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_dut2: got %b %0d %0d expected 0000 0 0", flags2, xfer2, err2); end
    n_checks++; if (code1 !== 4'b0 || idx1 !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_first: got %b %0d expected 0000 0", code1, idx1); end
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_clean_bursts();
    int d0;
    d0 = obs_done[0];
    applyStimulus(0, 2, 2, 0, 1, 16'h00A5, 0);
    applyStimulus(0, 3, 3, 0, 1, 16'h00A5, 0);
    applyStimulus(0, 4, 4, 0, 1, 16'h00A5, 0);
    n_checks++; if (xfer1 !== 16'd3) begin n_fail++; $display("[TB] FAIL clean_xfer: got %0d expected 3", xfer1); end
    n_checks++; if (flags1 !== 4'b0 || err1 !== 16'd0) begin n_fail++; $display("[TB] FAIL clean_flags: got %b/%0d expected 0000/0", flags1, err1); end
    n_checks++; if (obs_done[0] - d0 !== 3) begin n_fail++; $display("[TB] FAIL clean_done: got %0d expected 3", obs_done[0] - d0); end
  endtask

  task automatic test_early_ack();
    int p0;
    p0 = obs_errp[0];
    applyStimulus(0, 2, 1, 0, 1, 16'h00A5, 0);
    n_checks++; if (flags1 !== 4'b0100) begin n_fail++; $display("[TB] FAIL early_flags: got %b expected 0100", flags1); end
    n_checks++; if (err1 !== 16'd1 || xfer1 !== 16'd3) begin n_fail++; $display("[TB] FAIL early_counts: got %0d/%0d expected 1/3", err1, xfer1); end
    n_checks++; if (obs_errp[0] - p0 !== 1) begin n_fail++; $display("[TB] FAIL early_pulse: got %0d expected 1", obs_errp[0] - p0); end
  endtask

  task automatic test_overrun();
    int p0;
    do_clear(0);
    p0 = obs_errp[0];
    applyStimulus(0, 5, 0, 0, 1, 16'h00A5, 0);
    n_checks++; if (flags1 !== 4'b0101) begin n_fail++; $display("[TB] FAIL overrun_flags: got %b expected 0101", flags1); end
    n_checks++; if (err1 !== 16'd1 || xfer1 !== 16'd0) begin n_fail++; $display("[TB] FAIL overrun_counts: got %0d/%0d expected 1/0", err1, xfer1); end
    n_checks++; if (obs_errp[0] - p0 !== 1) begin n_fail++; $display("[TB] FAIL overrun_pulse: got %0d expected 1", obs_errp[0] - p0); end
  endtask

  task automatic test_drop_and_data();
    do_clear(0);
    applyStimulus(0, 3, 2, 0, 1, 16'h00A5, 0);
    n_checks++; if (flags1 !== 4'b1000) begin n_fail++; $display("[TB] FAIL drop_flags: got %b expected 1000", flags1); end
    do_clear(0);
    applyStimulus(0, 2, 2, 2, 1, 16'h003C, 0);
    n_checks++; if (flags1 !== 4'b0010) begin n_fail++; $display("[TB] FAIL data_flags: got %b expected 0010", flags1); end
    n_checks++; if (err1 !== 16'd1) begin n_fail++; $display("[TB] FAIL data_count: got %0d expected 1", err1); end
  endtask

  task automatic test_cfg2();
    int d0;
    applyStimulus(1, 6, 6, 0, 1, 16'hBEEF, 0);
    n_checks++; if (flags2 !== 4'b0 || xfer2 !== 2'd1) begin n_fail++; $display("[TB] FAIL cfg2_clean: got %b/%0d expected 0000/1", flags2, xfer2); end
    applyStimulus(1, 2, 0, 0, 1, 16'hBEEF, 0);
    n_checks++; if (flags2 !== 4'b0101 || err2 !== 2'd1) begin n_fail++; $display("[TB] FAIL cfg2_short: got %b/%0d expected 0101/1", flags2, err2); end
    do_clear(1);
    d0 = obs_done[1];
    for (int i = 0; i < 5; i++) applyStimulus(1, 3, 3, 0, 1, 16'h1234, 0);
    n_checks++; if (xfer2 !== 2'd3) begin n_fail++; $display("[TB] FAIL cfg2_saturate: got %0d expected 3", xfer2); end
    n_checks++; if (obs_done[1] - d0 !== 5 || err2 !== 2'd0) begin n_fail++; $display("[TB] FAIL cfg2_done: got %0d/%0d expected 5/0", obs_done[1] - d0, err2); end
  endtask

  task automatic test_clr_collision();
    @(negedge clk); set_in(0, 1'b0, 1'b1, 16'h0, 1'b1);
    @(negedge clk); set_in(0, 1'b0, 1'b0, 16'h0, 1'b0);
    model_clear(0);
    model_end(0, 4'b0100);
    exp_errp[0]++;
    @(negedge clk); #1;
    n_checks++; if (flags1 !== 4'b0100) begin n_fail++; $display("[TB] FAIL clr_flags: got %b expected 0100", flags1); end
    n_checks++; if (err1 !== 16'd1 || xfer1 !== 16'd0) begin n_fail++; $display("[TB] FAIL clr_counts: got %0d/%0d expected 1/0", err1, xfer1); end
    n_checks++; if (code1 !== (FIRST_EN ? 4'b0100 : 4'b0000)) begin n_fail++; $display("[TB] FAIL clr_first_code: got %b expected %b", code1, FIRST_EN ? 4'b0100 : 4'b0000); end
    n_checks++; if (idx1 !== (FIRST_EN ? 16'd1 : 16'd0)) begin n_fail++; $display("[TB] FAIL clr_first_idx: got %0d expected %0d", idx1, FIRST_EN ? 1 : 0); end
  endtask

  task automatic test_reset_release();
    @(negedge clk); set_in(0, 1'b1, 1'b0, 16'h00A5, 1'b0);
    @(negedge clk); set_in(0, 1'b1, 1'b0, 16'h00A5, 1'b0);
    #2 reset = 1'b0;
    #1;
    model_reset();
    n_checks++; if (flags1 !== 4'b0 || err1 !== 16'd0) begin n_fail++; $display("[TB] FAIL midreset_dut1: got %b/%0d expected 0000/0", flags1, err1); end
    n_checks++; if (xfer2 !== 2'd0) begin n_fail++; $display("[TB] FAIL midreset_dut2: got %0d expected 0", xfer2); end
    @(negedge clk); reset = 1'b1;
    @(negedge clk); set_in(0, 1'b1, 1'b1, 16'h00A5, 1'b0);
    @(negedge clk); set_in(0, 1'b1, 1'b0, 16'h0055, 1'b0);
    @(negedge clk); set_in(0, 1'b0, 1'b0, 16'h00A5, 1'b0);
    applyStimulus(0, 2, 2, 0, 1, 16'h00A5, 0);
    n_checks++; if (xfer1 !== 16'd1) begin n_fail++; $display("[TB] FAIL release_xfer: got %0d expected 1", xfer1); end
    n_checks++; if (flags1 !== 4'b0 || err1 !== 16'd0) begin n_fail++; $display("[TB] FAIL release_flags: got %b/%0d expected 0000/0", flags1, err1); end
  endtask

  task automatic test_random();
    int sel, L, a, c, G;
    for (int t = 0; t < 200; t++) begin
      sel = (t % 4 == 3) ? 1 : 0;
      if ($urandom_range(0, 24) == 0) do_clear(sel);
      L = $urandom_range(1, max_v[sel] + 2);
      a = ($urandom_range(0, 2) == 0) ? L : $urandom_range(0, L);
      c = (L >= 2 && $urandom_range(0, 3) == 0) ? $urandom_range(2, L) : 0;
      G = $urandom_range(1, 3);
      applyStimulus(sel, L, a, c, G, 16'($urandom), $urandom_range(0, 15));
      n_checks++; if (obs_flags(sel) !== exp_flags[sel]) begin n_fail++; $display("[TB] FAIL rand_flags[%0d] t=%0d: got %b expected %b", sel, t, obs_flags(sel), exp_flags[sel]); end
      n_checks++; if (obs_xfer(sel) !== exp_xfer[sel]) begin n_fail++; $display("[TB] FAIL rand_xfer[%0d] t=%0d: got %0d expected %0d", sel, t, obs_xfer(sel), exp_xfer[sel]); end
      n_checks++; if (obs_err(sel) !== exp_err[sel]) begin n_fail++; $display("[TB] FAIL rand_err[%0d] t=%0d: got %0d expected %0d", sel, t, obs_err(sel), exp_err[sel]); end
      n_checks++; if (obs_done[sel] !== exp_done[sel]) begin n_fail++; $display("[TB] FAIL rand_done[%0d] t=%0d: got %0d expected %0d", sel, t, obs_done[sel], exp_done[sel]); end
      n_checks++; if (obs_errp[sel] !== exp_errp[sel]) begin n_fail++; $display("[TB] FAIL rand_pulse[%0d] t=%0d: got %0d expected %0d", sel, t, obs_errp[sel], exp_errp[sel]); end
      n_checks++; if (obs_code(sel) !== (FIRST_EN ? exp_code[sel] : 4'b0)) begin n_fail++; $display("[TB] FAIL rand_code[%0d] t=%0d: got %b expected %b", sel, t, obs_code(sel), FIRST_EN ? exp_code[sel] : 4'b0); end
      n_checks++; if (obs_idx(sel) !== (FIRST_EN ? exp_idx[sel] : 0)) begin n_fail++; $display("[TB] FAIL rand_idx[%0d] t=%0d: got %0d expected %0d", sel, t, obs_idx(sel), FIRST_EN ? exp_idx[sel] : 0); end
    end
  endtask

  initial begin
    exp_done = '{0, 0};
    exp_errp = '{0, 0};
    $display("[TB] bus_protocol_monitor bench start");
    test_reset();
    test_clean_bursts();
    test_early_ack();
    test_overrun();
    test_drop_and_data();
    test_cfg2();
    test_clr_collision();
    test_reset_release();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
